// File: rtl/srff_pkg.sv
// Shared definitions for the SR flip-flop command path: command codes and
// the command generator state encoding.
package srff_pkg;

  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_CLR     = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_COOLDOWN = 2'd2
  } sr_state_e;

endpackage

// File: rtl/sr_debounce.sv
// Debounces one raw request line into a level, plus a registered one-cycle
// flag on each 0->1 flip of that level.
module sr_debounce
  import srff_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (raw_in == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt >= CNT_LAST) begin
        // DB_CYCLES-th differing sample in a row: commit the new level
        r_level <= raw_in;
        r_cnt   <= '0;
        r_rise  <= raw_in;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

// File: rtl/sr_cmd_gen.sv
// SR command generator: debounced set/clear requests become single-cycle
// SR codes separated by a cool-down gap; simultaneous requests are dropped.
module sr_cmd_gen
  import srff_pkg::*;
#(
  parameter int DB_CYCLES  = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_req,
  input  logic       clr_req,
  output logic [1:0] sr,
  output logic       busy,
  output logic       conflict
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  logic w_set_level, w_set_rise, w_clr_level, w_clr_rise;
  logic w_set_evt, w_clr_evt, w_s, w_c;

  sr_state_e     r_state, w_state_nxt;
  logic [GW-1:0] r_gap, w_gap_nxt;
  logic          r_pend_set, r_pend_clr, w_pend_set_nxt, w_pend_clr_nxt;
  logic [1:0]    r_sr, w_sr_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_conflict, w_conflict_nxt;

  sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk    (clk),
    .rst    (rst),
    .raw_in (set_req),
    .level  (w_set_level),
    .rise   (w_set_rise)
  );

  sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk    (clk),
    .rst    (rst),
    .raw_in (clr_req),
    .level  (w_clr_level),
    .rise   (w_clr_rise)
  );

  // A rise flag is only ever raised together with a high level
  assign w_set_evt = w_set_rise & w_set_level;
  assign w_clr_evt = w_clr_rise & w_clr_level;
  assign w_s       = w_set_evt | r_pend_set;
  assign w_c       = w_clr_evt | r_pend_clr;

  always_comb begin
    w_state_nxt    = r_state;
    w_gap_nxt      = r_gap;
    w_pend_set_nxt = r_pend_set;
    w_pend_clr_nxt = r_pend_clr;
    w_sr_nxt       = SR_HOLD;
    w_conflict_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pend_set_nxt = 1'b0;
        w_pend_clr_nxt = 1'b0;
        if (w_s && w_c) begin
          w_conflict_nxt = 1'b1;
        end else if (w_s) begin
          w_state_nxt = ST_ISSUE;
          w_sr_nxt    = SR_SET;
        end else if (w_c) begin
          w_state_nxt = ST_ISSUE;
          w_sr_nxt    = SR_CLR;
        end
      end
      ST_ISSUE: begin
        w_pend_set_nxt = r_pend_set | w_set_evt;
        w_pend_clr_nxt = r_pend_clr | w_clr_evt;
        w_state_nxt    = ST_COOLDOWN;
        w_gap_nxt      = GAP_LOAD;
      end
      ST_COOLDOWN: begin
        w_pend_set_nxt = r_pend_set | w_set_evt;
        w_pend_clr_nxt = r_pend_clr | w_clr_evt;
        if (r_gap == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt = r_gap - GW'(1);
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_pend_set_nxt = 1'b0;
        w_pend_clr_nxt = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gap      <= '0;
      r_pend_set <= 1'b0;
      r_pend_clr <= 1'b0;
      r_sr       <= SR_HOLD;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gap      <= w_gap_nxt;
      r_pend_set <= w_pend_set_nxt;
      r_pend_clr <= w_pend_clr_nxt;
      r_sr       <= w_sr_nxt;
      r_busy     <= w_busy_nxt;
      r_conflict <= w_conflict_nxt;
    end
  end

  assign sr       = r_sr;
  assign busy     = r_busy;
  assign conflict = r_conflict;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen: reset, clean/bounced requests, conflicts,
// pending requests and a random-bounce guard on the emitted codes.
module tb_sr_cmd_gen;
  import srff_pkg::*;

  logic       clk = 1'b0;
  logic       rst, set_req, clr_req, l_set, l_clr;
  logic [1:0] sr, l_sr;
  logic       busy, conflict, l_busy, l_conflict;

  int checks = 0;
  int errors = 0;
  int n_cmds = 0;
  int zeros  = 0;
  int n_before;
  bit have_prev = 1'b0;
  logic [6:0] pat = 7'b1111011;

  always #5 clk = ~clk;

  sr_cmd_gen #(.DB_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .set_req  (set_req),
    .clr_req  (clr_req),
    .sr       (sr),
    .busy     (busy),
    .conflict (conflict)
  );

  // Longer gap so two events of different type can gather in one cool-down
  sr_cmd_gen #(.DB_CYCLES(4), .GAP_CYCLES(10)) dut_long (
    .clk      (clk),
    .rst      (rst),
    .set_req  (l_set),
    .clr_req  (l_clr),
    .sr       (l_sr),
    .busy     (l_busy),
    .conflict (l_conflict)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Watches every cycle for the illegal code and for commands spaced too tightly
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      assert (sr !== SR_ILLEGAL) else begin
        errors++;
        $error("FAIL illegal_code: observed %0h expected not 3", sr);
      end
      if (sr !== SR_HOLD) begin
        if (have_prev) begin
          checks++;
          assert (zeros >= 2) else begin
            errors++;
            $error("FAIL cmd_spacing: observed %0d expected >=2", zeros);
          end
        end
        n_cmds++;
        have_prev = 1'b1;
        zeros = 0;
      end else begin
        zeros++;
      end
    end
  end

  initial begin
    rst = 1'b1; set_req = 1'b0; clr_req = 1'b0; l_set = 1'b0; l_clr = 1'b0;
    ticks(3);
    chk("rst_sr", sr, SR_HOLD);
    chk("rst_busy", busy, 1'b0);
    chk("rst_conflict", conflict, 1'b0);
    rst = 1'b0;
    ticks(2);

    // clean set: code visible DB_CYCLES+1 edges after first sample
    set_req = 1'b1;
    ticks(4);
    chk("set_early", sr, SR_HOLD);
    tick();
    chk("set_issue", sr, SR_SET);
    chk("set_issue_busy", busy, 1'b1);
    tick();
    chk("set_cool1", sr, SR_HOLD);
    chk("set_cool1_busy", busy, 1'b1);
    tick();
    chk("set_cool2_busy", busy, 1'b1);
    tick();
    chk("set_idle_busy", busy, 1'b0);
    chk("set_count", n_cmds, 1);
    set_req = 1'b0;
    ticks(6);
    chk("fall_no_cmd", n_cmds, 1);

    // bounce 1,1,0,1,1,1,1
    for (int i = 0; i < 7; i++) begin
      set_req = pat[i];
      tick();
    end
    chk("bounce_wait", sr, SR_HOLD);
    chk("bounce_count_pre", n_cmds, 1);
    tick();
    chk("bounce_issue", sr, SR_SET);
    ticks(6);
    chk("bounce_single", n_cmds, 2);
    set_req = 1'b0;
    ticks(6);

    // simultaneous rise on both lines
    set_req = 1'b1; clr_req = 1'b1;
    ticks(4);
    chk("conf_early", conflict, 1'b0);
    tick();
    chk("conf_pulse", conflict, 1'b1);
    chk("conf_sr", sr, SR_HOLD);
    chk("conf_busy", busy, 1'b0);
    tick();
    chk("conf_end", conflict, 1'b0);
    ticks(4);
    chk("conf_no_cmd", n_cmds, 2);
    set_req = 1'b0; clr_req = 1'b0;
    ticks(6);

    // clear event lands during the set command's cool-down
    set_req = 1'b1;
    ticks(2);
    clr_req = 1'b1;
    ticks(3);
    chk("pend_set_issue", sr, SR_SET);
    ticks(3);
    chk("pend_idle_sr", sr, SR_HOLD);
    chk("pend_idle_busy", busy, 1'b0);
    tick();
    chk("pend_clr_issue", sr, SR_CLR);
    tick();
    chk("pend_clr_cool", sr, SR_HOLD);
    chk("pend_clr_busy", busy, 1'b1);
    ticks(3);
    chk("pend_count", n_cmds, 4);
    set_req = 1'b0; clr_req = 1'b0;
    ticks(6);

    // set and clear events both pending in one long cool-down
    l_set = 1'b1;
    ticks(4);
    l_set = 1'b0;
    tick();
    chk("long_set_issue", l_sr, SR_SET);
    l_clr = 1'b1;
    ticks(3);
    l_set = 1'b1;
    ticks(7);
    chk("long_cool_busy", l_busy, 1'b1);
    chk("long_cool_sr", l_sr, SR_HOLD);
    tick();
    chk("long_idle_busy", l_busy, 1'b0);
    tick();
    chk("long_conf_pulse", l_conflict, 1'b1);
    chk("long_conf_sr", l_sr, SR_HOLD);
    tick();
    chk("long_conf_end", l_conflict, 1'b0);
    ticks(3);
    chk("long_no_cmd_sr", l_sr, SR_HOLD);
    chk("long_no_cmd_busy", l_busy, 1'b0);
    l_set = 1'b0; l_clr = 1'b0;

    // asynchronous reset while the set code is on the output
    set_req = 1'b1;
    ticks(5);
    chk("async_pre", sr, SR_SET);
    #2;
    rst = 1'b1;
    #1;
    chk("async_sr", sr, SR_HOLD);
    chk("async_busy", busy, 1'b0);
    chk("async_conflict", conflict, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ticks(4);
    chk("held_early", sr, SR_HOLD);
    tick();
    chk("held_issue", sr, SR_SET);
    set_req = 1'b0;
    ticks(8);

    // random bouncing on both lines; the monitor guards code and spacing
    n_before = n_cmds;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) set_req = ~set_req;
      if ($urandom_range(0, 5) == 0) clr_req = ~clr_req;
      tick();
    end
    set_req = 1'b0; clr_req = 1'b0;
    ticks(10);
    chk("rand_activity", (n_cmds > n_before), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
